// File: rtl/rv_boot_pkg.sv
// Shared state encoding and word geometry for the boot loader.
package rv_boot_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      HDR_ADDR = 3'd0,
      HDR_CNT  = 3'd1,
      LOAD     = 3'd2,
      RELEASE  = 3'd3,
      START    = 3'd4,
      RUN      = 3'd5
   } boot_state_t;

endpackage

// File: rtl/rv_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word/word_done are combinational on the 4th byte.
// No backpressure of its own: it takes a byte whenever accept is high.
module rv_byte_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  byte_cnt;
   logic [23:0] low_bytes;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byte_cnt  <= 2'd0;
         low_bytes <= 24'd0;
      end else if (clear) begin
         byte_cnt  <= 2'd0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         case (byte_cnt)
            2'd0:    low_bytes[7:0]   <= byte_data;
            2'd1:    low_bytes[15:8]  <= byte_data;
            2'd2:    low_bytes[23:16] <= byte_data;
            default: ;
         endcase
      end
   end

   // Top byte bypasses storage so the full word is ready the cycle it arrives.
   assign word      = {byte_data, low_bytes};
   assign word_done = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/rv_boot_loader.sv
// Loads a header+payload byte stream into instruction memory, then releases and starts the core.
// Write lands 1 cycle after the 4th byte; memory never stalls, in_ready drops outside header/load.
import rv_boot_pkg::*;

module rv_boot_loader #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int CNT_BITS     = 18
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   input  logic                    reboot,
   output logic                    imem_we,
   output logic [ADDRESS_BITS-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0]   imem_wdata,
   output logic                    core_reset,
   output logic                    core_start,
   output logic [ADDRESS_BITS-1:0] prog_address,
   output logic                    busy
);

   boot_state_t             state, state_nxt;
   logic                    rdy_en;
   logic [ADDRESS_BITS-1:0] load_ptr;
   logic [CNT_BITS-1:0]     remaining;
   logic [31:0]             word;
   logic                    word_done;
   logic                    accept;
   logic                    pack_clear;

   // LOAD with nothing remaining is the cycle the last write is on the bus; stop taking bytes.
   assign in_ready = rdy_en && ((state == HDR_ADDR) || (state == HDR_CNT) ||
                                ((state == LOAD) && (remaining != '0)));
   assign accept   = in_valid && in_ready;

   rv_byte_packer u_packer (
      .clock     (clock),
      .reset     (reset),
      .clear     (pack_clear),
      .accept    (accept),
      .byte_data (in_data),
      .word      (word),
      .word_done (word_done)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= HDR_ADDR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      core_reset = 1'b1;
      core_start = 1'b0;
      busy       = 1'b1;
      pack_clear = 1'b0;
      case (state)
         HDR_ADDR: if (word_done) state_nxt = HDR_CNT;
         HDR_CNT:  if (word_done) state_nxt = (word[CNT_BITS-1:0] == '0) ? RELEASE : LOAD;
         LOAD:     if (remaining == '0) state_nxt = RELEASE;
         RELEASE: begin
            core_reset = 1'b0;
            state_nxt  = START;
         end
         START: begin
            core_reset = 1'b0;
            core_start = 1'b1;
            state_nxt  = RUN;
         end
         RUN: begin
            core_reset = 1'b0;
            busy       = 1'b0;
            if (reboot) begin
               state_nxt  = HDR_ADDR;
               pack_clear = 1'b1;
            end
         end
         default: state_nxt = HDR_ADDR;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdy_en       <= 1'b0;
         load_ptr     <= '0;
         remaining    <= '0;
         prog_address <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
      end else begin
         rdy_en  <= 1'b1;
         imem_we <= 1'b0;
         if (word_done) begin
            case (state)
               HDR_ADDR: begin
                  prog_address <= {word[ADDRESS_BITS-1:2], 2'b00};
                  load_ptr     <= {word[ADDRESS_BITS-1:2], 2'b00};
               end
               HDR_CNT: remaining <= word[CNT_BITS-1:0];
               LOAD: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= load_ptr;
                  imem_wdata <= word;
                  load_ptr   <= load_ptr + ADDRESS_BITS'(BYTES_PER_WORD);
                  remaining  <= remaining - CNT_BITS'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rv_boot_loader.sv
// Directed bench for rv_boot_loader: image loads, header corner cases, flow control, reset and reboot.
module tb_rv_boot_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        reboot = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [19:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        core_start;
   logic [19:0] prog_address;
   logic        busy;

   int total = 0;
   int bad   = 0;

   rv_boot_loader dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .reboot       (reboot),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .core_start   (core_start),
      .prog_address (prog_address),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   // Observation of DUT activity, sampled on the falling edge.
   int          cyc = 0;
   logic [19:0] w_addr_q[$];
   logic [31:0] w_data_q[$];
   int          w_cyc_q[$];
   int          start_cnt = 0;
   int          start_cyc = -1;
   int          rst_fall_cyc = -1;
   int          acc_cnt = 0;
   int          last_acc_cyc = -1;
   logic        prev_cr = 1'b1;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (imem_we) begin
         w_addr_q.push_back(imem_addr);
         w_data_q.push_back(imem_wdata);
         w_cyc_q.push_back(cyc);
      end
      if (core_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (prev_cr && !core_reset) rst_fall_cyc = cyc;
      prev_cr = core_reset;
      if (in_valid && in_ready) begin
         acc_cnt++;
         last_acc_cyc = cyc;
      end
   end

   task automatic clr_mon();
      w_addr_q.delete();
      w_data_q.delete();
      w_cyc_q.delete();
      start_cnt    = 0;
      start_cyc    = -1;
      rst_fall_cyc = -1;
      acc_cnt      = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gapped);
      int n;
      if (gapped) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (!in_ready) begin
         bad++;
         $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gapped);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gapped);
   endtask

   task automatic wait_start();
      int n = 0;
      while (start_cnt == 0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (start_cnt == 0) begin
         bad++;
         $display("FAIL wait_start_timeout: start_cnt=%0d required >0", start_cnt);
      end
      repeat (4) @(negedge clock);
   endtask

   task automatic do_reboot();
      reboot = 1'b1;
      @(posedge clock);
      #1;
      reboot = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (5) @(negedge clock);
      total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset: got %0b want 1", core_reset); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
      total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_imem_we: got %0b want 0", imem_we); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %0b want 1", busy); end
      total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start: got %0b want 0", core_start); end
      total++; if (prog_address !== 20'h0) begin bad++; $display("FAIL rst_prog_address: got %h want 00000", prog_address); end
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_in_ready: got %0b want 0", in_ready); end
      @(negedge clock);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_next_in_ready: got %0b want 1", in_ready); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_basic();
      logic [19:0] ea[2] = '{20'h00100, 20'h00104};
      logic [31:0] ed[2] = '{32'h00000013, 32'h0000006F};
      clr_mon();
      send_word(32'h00000100, 1'b0);
      send_word(32'h00000002, 1'b0);
      send_word(32'h00000013, 1'b0);
      send_word(32'h0000006F, 1'b0);
      wait_start();
      total++;
      if (w_addr_q.size() != 2) begin
         bad++; $display("FAIL basic_write_count: got %0d want 2", w_addr_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (w_addr_q[i] !== ea[i] || w_data_q[i] !== ed[i]) begin
               bad++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i, w_addr_q[i], w_data_q[i], ea[i], ed[i]);
            end
         end
         total++; if (w_cyc_q[1] != last_acc_cyc + 1) begin bad++; $display("FAIL basic_write_latency: got %0d want %0d", w_cyc_q[1], last_acc_cyc + 1); end
         total++; if (rst_fall_cyc != w_cyc_q[1] + 1) begin bad++; $display("FAIL basic_core_reset_fall: got %0d want %0d", rst_fall_cyc, w_cyc_q[1] + 1); end
         total++; if (start_cyc != w_cyc_q[1] + 2) begin bad++; $display("FAIL basic_start_cycle: got %0d want %0d", start_cyc, w_cyc_q[1] + 2); end
      end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL basic_start_count: got %0d want 1", start_cnt); end
      total++; if (prog_address !== 20'h00100) begin bad++; $display("FAIL basic_prog_address: got %h want 00100", prog_address); end
      total++; if (busy !== 1'b0 || core_reset !== 1'b0) begin bad++; $display("FAIL basic_run_flags: got busy=%0b core_reset=%0b want 0/0", busy, core_reset); end
      total++; if (acc_cnt != 16) begin bad++; $display("FAIL basic_accepts: got %0d want 16", acc_cnt); end
   endtask

   task automatic test_count_zero();
      do_reboot();
      clr_mon();
      send_word(32'h00000107, 1'b0);
      send_word(32'h00000000, 1'b0);
      wait_start();
      total++; if (w_addr_q.size() != 0) begin bad++; $display("FAIL zero_write_count: got %0d want 0", w_addr_q.size()); end
      total++; if (prog_address !== 20'h00104) begin bad++; $display("FAIL zero_prog_address: got %h want 00104", prog_address); end
      total++; if (rst_fall_cyc != last_acc_cyc + 1) begin bad++; $display("FAIL zero_core_reset_fall: got %0d want %0d", rst_fall_cyc, last_acc_cyc + 1); end
      total++; if (start_cyc != last_acc_cyc + 2 || start_cnt != 1) begin bad++; $display("FAIL zero_start: got cyc=%0d cnt=%0d want cyc=%0d cnt=1", start_cyc, start_cnt, last_acc_cyc + 2); end
   endtask

   task automatic test_wrap();
      logic [19:0] ea[2] = '{20'hFFFFC, 20'h00000};
      logic [31:0] ed[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A};
      do_reboot();
      clr_mon();
      send_word(32'h000FFFFC, 1'b0);
      send_word(32'h00000002, 1'b0);
      send_word(32'hA5A5A5A5, 1'b0);
      send_word(32'h5A5A5A5A, 1'b0);
      wait_start();
      total++;
      if (w_addr_q.size() != 2) begin
         bad++; $display("FAIL wrap_write_count: got %0d want 2", w_addr_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (w_addr_q[i] !== ea[i] || w_data_q[i] !== ed[i]) begin
               bad++; $display("FAIL wrap_write%0d: got %h/%h want %h/%h", i, w_addr_q[i], w_data_q[i], ea[i], ed[i]);
            end
         end
      end
      total++; if (prog_address !== 20'hFFFFC) begin bad++; $display("FAIL wrap_prog_address: got %h want FFFFC", prog_address); end
   endtask

   task automatic test_gapped_junk();
      logic [19:0] ea[3] = '{20'h00300, 20'h00304, 20'h00308};
      logic [31:0] ed[3] = '{32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF};
      do_reboot();
      clr_mon();
      send_word(32'h00000300, 1'b1);
      send_word(32'h00000003, 1'b1);
      do_reboot();
      for (int i = 0; i < 3; i++) send_word(ed[i], 1'b1);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      wait_start();
      repeat (8) @(negedge clock);
      in_valid = 1'b0;
      total++;
      if (w_addr_q.size() != 3) begin
         bad++; $display("FAIL gap_write_count: got %0d want 3", w_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (w_addr_q[i] !== ea[i] || w_data_q[i] !== ed[i]) begin
               bad++; $display("FAIL gap_write%0d: got %h/%h want %h/%h", i, w_addr_q[i], w_data_q[i], ea[i], ed[i]);
            end
         end
      end
      total++; if (acc_cnt != 20) begin bad++; $display("FAIL gap_accepts: got %0d want 20", acc_cnt); end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL gap_start_count: got %0d want 1", start_cnt); end
      total++; if (prog_address !== 20'h00300) begin bad++; $display("FAIL gap_prog_address: got %h want 00300", prog_address); end
   endtask

   task automatic test_reset_midload();
      logic [7:0] pl[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_reboot();
      clr_mon();
      send_word(32'h00000500, 1'b0);
      send_word(32'h00000002, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(pl[i], 1'b0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++;
      if (w_addr_q.size() != 1 || w_addr_q[0] !== 20'h00500 || w_data_q[0] !== 32'h44332211) begin
         bad++; $display("FAIL midload_partial_writes: got n=%0d want one write 00500/44332211", w_addr_q.size());
      end
      total++; if (core_reset !== 1'b1 || busy !== 1'b1 || imem_we !== 1'b0) begin bad++; $display("FAIL midload_reset_flags: got cr=%0b busy=%0b we=%0b want 1/1/0", core_reset, busy, imem_we); end
      total++; if (prog_address !== 20'h0) begin bad++; $display("FAIL midload_prog_cleared: got %h want 00000", prog_address); end
      reset = 1'b1;
      @(posedge clock);
      #1;
      clr_mon();
      send_word(32'h00000200, 1'b0);
      send_word(32'h00000001, 1'b0);
      send_word(32'h11223344, 1'b0);
      wait_start();
      total++;
      if (w_addr_q.size() != 1 || w_addr_q[0] !== 20'h00200 || w_data_q[0] !== 32'h11223344) begin
         bad++; $display("FAIL midload_reload_write: got n=%0d want one write 00200/11223344", w_addr_q.size());
      end
      total++; if (prog_address !== 20'h00200 || start_cnt != 1) begin bad++; $display("FAIL midload_reload_start: got %h cnt=%0d want 00200 cnt=1", prog_address, start_cnt); end
   endtask

   task automatic test_reboot();
      clr_mon();
      do_reboot();
      @(negedge clock);
      total++; if (core_reset !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL reboot_flags: got cr=%0b busy=%0b rdy=%0b want 1/1/1", core_reset, busy, in_ready); end
      total++; if (prog_address !== 20'h00200) begin bad++; $display("FAIL reboot_prog_hold: got %h want 00200", prog_address); end
      @(posedge clock);
      #1;
      send_word(32'h00000400, 1'b0);
      total++; if (prog_address !== 20'h00400) begin bad++; $display("FAIL reboot_prog_new: got %h want 00400", prog_address); end
      send_word(32'h00000001, 1'b0);
      send_word(32'hDEADBEEF, 1'b0);
      wait_start();
      total++;
      if (w_addr_q.size() != 1 || w_addr_q[0] !== 20'h00400 || w_data_q[0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL reboot_write: got n=%0d want one write 00400/DEADBEEF", w_addr_q.size());
      end
      total++; if (start_cnt != 1 || busy !== 1'b0) begin bad++; $display("FAIL reboot_start: got cnt=%0d busy=%0b want 1/0", start_cnt, busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_count_zero();
      test_wrap();
      test_gapped_junk();
      test_reset_midload();
      test_reboot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
